// File: rtl/keyboard_ctrl_pkg.sv
// Shared keyboard/piano definitions: mode and pitch codes,
// octave mapping and the priority-register bundle.
package keyboard_ctrl_pkg;

  localparam logic [2:0] MODE_FREE  = 3'b001;
  localparam logic [1:0] PITCH_LOW  = 2'b01;
  localparam logic [1:0] PITCH_MID  = 2'b00;
  localparam logic [1:0] PITCH_HIGH = 2'b10;
  localparam int         NOTE_SILENCE = 0;
  localparam int         IDX_W = 3;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } cur_t;

  // 3 marks an invalid pitch selection
  function automatic logic [1:0] oct_idx(input logic [1:0] p);
    logic [1:0] o;
    o = 2'd3;
    unique case (1'b1)
      (p == PITCH_LOW):  o = 2'd0;
      (p == PITCH_MID):  o = 2'd1;
      (p == PITCH_HIGH): o = 2'd2;
      default:           o = 2'd3;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key synchroniser, debounce tick and two-sample agreement filter.
// A bit only moves once two consecutive tick samples agree.
module key_debounce #(
  parameter int W        = 7,
  parameter int DEB_TICK = 2000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] key,
  output logic [W-1:0] kdb,
  output logic         tick
);

  localparam int CW = (DEB_TICK > 1) ? $clog2(DEB_TICK) : 1;

  logic [CW-1:0] cnt;
  logic [W-1:0]  s1;
  logic [W-1:0]  s2;
  logic [W-1:0]  samp;
  logic [W-1:0]  eq;

  assign tick = (cnt == CW'(DEB_TICK - 1));
  assign eq   = ~(s2 ^ samp);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      s1   <= '0;
      s2   <= '0;
      samp <= '0;
      kdb  <= '0;
    end else begin
      s1  <= key;
      s2  <= s1;
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        samp <= s2;
        kdb  <= (eq & s2) | (~eq & kdb);
      end
    end
  end

endmodule

// File: rtl/keyboard_ctrl.sv
// Free-mode keyboard front end: last-note priority, note encode,
// note_on/note_off pulses and hold duration.
module keyboard_ctrl
  import keyboard_ctrl_pkg::*;
#(
  parameter int NUM_KEYS = 7,
  parameter int NUM_OCT  = 3,
  parameter int NOTE_W   = 5,
  parameter int DEB_TICK = 2000000,
  parameter int DUR_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  input  logic [1:0]          pitch,
  input  logic [2:0]          mode,
  output logic [NOTE_W-1:0]   note,
  output logic                note_on,
  output logic                note_off,
  output logic [DUR_W-1:0]    hold_cnt
);

  logic [NUM_KEYS-1:0] kdb;
  logic [NUM_KEYS-1:0] kdb_q;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;
  logic                tick;
  logic                free;
  cur_t                cur;
  cur_t                cur_d;
  logic [NOTE_W-1:0]   nxt;
  logic                on_d;
  logic                off_d;
  int                  oct;

  key_debounce #(
    .W        (NUM_KEYS),
    .DEB_TICK (DEB_TICK)
  ) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key),
    .kdb   (kdb),
    .tick  (tick)
  );

  function automatic logic [IDX_W-1:0] lowest(
    input logic [NUM_KEYS-1:0] v
  );
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  assign rise = kdb & ~kdb_q;
  assign fall = ~kdb & kdb_q;
  assign free = (mode == MODE_FREE);
  assign oct  = int'(oct_idx(pitch));

  // newest press beats held keys; losing cur falls back to held keys
  always_comb begin
    cur_d = cur;
    if (!free) begin
      cur_d.vld = 1'b0;
    end else if (|rise) begin
      cur_d.idx = lowest(rise);
      cur_d.vld = 1'b1;
    end else if (cur.vld && fall[cur.idx]) begin
      if (|kdb) cur_d.idx = lowest(kdb);
      else      cur_d.vld = 1'b0;
    end
  end

  always_comb begin
    nxt = NOTE_W'(NOTE_SILENCE);
    if (free && cur.vld && oct < NUM_OCT)
      nxt = NOTE_W'(oct * NUM_KEYS + int'(cur.idx) + 1);
  end

  assign on_d  = (nxt != '0) && (nxt != note);
  assign off_d = (nxt == '0) && (note != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kdb_q    <= '0;
      cur      <= '0;
      note     <= '0;
      note_on  <= 1'b0;
      note_off <= 1'b0;
      hold_cnt <= '0;
    end else begin
      kdb_q    <= kdb;
      cur      <= cur_d;
      note     <= nxt;
      note_on  <= on_d;
      note_off <= off_d;
      if (on_d || nxt == '0)
        hold_cnt <= '0;
      else if (tick && hold_cnt != '1)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_keyboard_ctrl.sv
// Self-checking bench for keyboard_ctrl: directed table, corner
// sequences and randomized steps against a set-based note model.
module tb_keyboard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] key = '0;
  logic [1:0] pitch = 2'b00;
  logic [2:0] mode = 3'b001;
  logic [4:0] note;
  logic       note_on;
  logic       note_off;
  logic [7:0] hold_cnt;

  keyboard_ctrl #(
    .NUM_KEYS (7),
    .NUM_OCT  (3),
    .NOTE_W   (5),
    .DEB_TICK (4),
    .DUR_W    (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (key),
    .pitch    (pitch),
    .mode     (mode),
    .note     (note),
    .note_on  (note_on),
    .note_off (note_off),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  int pass_n = 0;
  int total_n = 0;
  int on_cnt = 0;
  int off_cnt = 0;

  always @(negedge clk) begin
    if (note_on === 1'b1) on_cnt++;
    if (note_off === 1'b1) off_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // reference model: sets of held keys and a "current note" choice
  logic [6:0] m_held = '0;
  int         m_cur = 0;
  bit         m_vld = 0;
  int         m_note = 0;

  function automatic int first_set(input logic [6:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 7; i++)
      if (v[i] && r < 0) r = i;
    return r;
  endfunction

  function automatic int octave(input logic [1:0] p);
    int r;
    case (p)
      2'b01:   r = 0;
      2'b00:   r = 1;
      2'b10:   r = 2;
      default: r = -1;
    endcase
    return r;
  endfunction

  task automatic mdl(input logic [6:0] k, input logic [1:0] p,
                     input logic [2:0] m);
    logic [6:0] pressed;
    logic [6:0] released;
    pressed  = k & ~m_held;
    released = m_held & ~k;
    if (m != 3'b001) begin
      m_vld = 0;
    end else if (pressed != 0) begin
      m_cur = first_set(pressed);
      m_vld = 1;
    end else if (m_vld && released[m_cur]) begin
      if (k != 0) m_cur = first_set(k);
      else m_vld = 0;
    end
    m_held = k;
    if (m == 3'b001 && m_vld && octave(p) >= 0)
      m_note = octave(p) * 7 + m_cur + 1;
    else
      m_note = 0;
  endtask

  task automatic step(input logic [6:0] k, input logic [1:0] p,
                      input logic [2:0] m, input string nm,
                      input int tbl_exp);
    int prev;
    int exp;
    @(posedge clk); #1;
    on_cnt = 0;
    off_cnt = 0;
    key = k;
    pitch = p;
    mode = m;
    prev = m_note;
    mdl(k, p, m);
    exp = (tbl_exp >= 0) ? tbl_exp : m_note;
    repeat (30) @(posedge clk);
    #1;
    chk({nm, "_note"}, int'(note), exp);
    chk({nm, "_on"}, on_cnt, (exp != 0 && exp != prev) ? 1 : 0);
    chk({nm, "_off"}, off_cnt, (exp == 0 && prev != 0) ? 1 : 0);
    if (exp == 0) chk({nm, "_hold0"}, int'(hold_cnt), 0);
  endtask

  typedef struct {
    logic [6:0] k;
    logic [1:0] p;
    logic [2:0] m;
    int         n;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{7'h01, 2'b00, 3'b001, 8};
    tbl[1]  = '{7'h00, 2'b00, 3'b001, 0};
    tbl[2]  = '{7'h01, 2'b00, 3'b001, 8};
    tbl[3]  = '{7'h11, 2'b00, 3'b001, 12};
    tbl[4]  = '{7'h01, 2'b00, 3'b001, 8};
    tbl[5]  = '{7'h00, 2'b00, 3'b001, 0};
    tbl[6]  = '{7'h40, 2'b01, 3'b001, 7};
    tbl[7]  = '{7'h40, 2'b10, 3'b001, 21};
    tbl[8]  = '{7'h40, 2'b11, 3'b001, 0};
    tbl[9]  = '{7'h40, 2'b00, 3'b001, 14};
    tbl[10] = '{7'h40, 2'b00, 3'b011, 0};
    tbl[11] = '{7'h40, 2'b00, 3'b001, 0};
    tbl[12] = '{7'h00, 2'b00, 3'b001, 0};
    tbl[13] = '{7'h40, 2'b00, 3'b001, 14};
    tbl[14] = '{7'h04, 2'b00, 3'b001, 10};
    tbl[15] = '{7'h02, 2'b00, 3'b001, 9};
    tbl[16] = '{7'h0a, 2'b00, 3'b001, 11};
    tbl[17] = '{7'h02, 2'b00, 3'b001, 9};
    tbl[18] = '{7'h00, 2'b00, 3'b001, 0};

    // reset with keys toggling
    for (int i = 0; i < 3; i++) begin
      key = 7'($urandom);
      @(posedge clk); #1;
      chk("rst_note", int'(note), 0);
      chk("rst_pulse", int'(note_on) + int'(note_off), 0);
      chk("rst_hold", int'(hold_cnt), 0);
    end
    key = '0;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);

    foreach (tbl[i])
      step(tbl[i].k, tbl[i].p, tbl[i].m, $sformatf("tbl%0d", i), tbl[i].n);

    // hold duration and saturation
    begin
      int seen;
      @(posedge clk); #1;
      on_cnt = 0;
      off_cnt = 0;
      key = 7'h40;
      mdl(7'h40, 2'b00, 3'b001);
      seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
        @(posedge clk); #1;
        if (note_on) seen = 1;
      end
      chk("hold_on_seen", seen, 1);
      chk("hold_note", int'(note), 14);
      repeat (40) @(posedge clk);
      #1;
      chk("hold_10ticks", int'(hold_cnt), 10);
      repeat (1200) @(posedge clk);
      #1;
      chk("hold_sat", int'(hold_cnt), 255);
      chk("hold_on_cnt", on_cnt, 1);
      chk("hold_off_cnt", off_cnt, 0);
    end

    // reset while a note sounds: silence without note_off
    @(posedge clk); #1;
    off_cnt = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_note", int'(note), 0);
    chk("midrst_hold", int'(hold_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_off", off_cnt, 0);
    m_held = '0;
    m_vld = 0;
    m_note = 0;
    step(7'h40, 2'b00, 3'b001, "postrst", 14);
    step(7'h00, 2'b00, 3'b001, "postrst_rel", 0);

    // bouncing key2 settles once
    @(posedge clk); #1;
    on_cnt = 0;
    off_cnt = 0;
    key = 7'h04;
    for (int i = 0; i < 5; i++) begin
      repeat (2) @(posedge clk);
      #1;
      key[2] = ~key[2];
    end
    key = 7'h04;
    mdl(7'h04, 2'b00, 3'b001);
    repeat (30) @(posedge clk);
    #1;
    chk("bounce_note", int'(note), 10);
    chk("bounce_on", on_cnt, 1);
    chk("bounce_off", off_cnt, 0);

    // randomized steps against the model
    for (int s = 0; s < 150; s++) begin
      int sel;
      logic [6:0] nk;
      logic [1:0] np;
      logic [2:0] nm;
      sel = int'($urandom_range(0, 99));
      nk = key;
      np = pitch;
      nm = mode;
      if (sel < 55)
        nk = key ^ 7'(1 << $urandom_range(0, 6));
      else if (sel < 70)
        nk = 7'($urandom);
      else if (sel < 85)
        np = 2'($urandom);
      else
        nm = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom);
      step(nk, np, nm, $sformatf("rnd%0d", s), -1);
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
